// File: rtl/muldiv_seq.sv
// muldiv_seq: iterative radix-2 multiply/divide sequencer for the EX stage.
module muldiv_seq #(
  parameter int XLEN  = 64,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid_i,
  input  logic            mul_en_i,
  input  logic [XLEN-1:0] rs1_data_i,
  input  logic [XLEN-1:0] rs2_data_i,
  input  logic            rs1_sign_i,
  input  logic            rs2_sign_i,
  input  logic            flush_i,
  output logic [XLEN-1:0] data_1_o,
  output logic [XLEN-1:0] data_2_o,
  output logic            valid_o,
  output logic            busy_o,
  output logic            stall_o
);
  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [XLEN-1:0]  r_op, r_hi, r_lo;
  logic             r_mul, r_neg_q, r_neg_r;
  logic             w_sa, w_sb, w_div0, w_ovf;
  logic [XLEN-1:0]  w_mag1, w_mag2;
  logic [XLEN:0]    w_add, w_sh, w_diff;
  assign w_sa   = rs1_sign_i & rs1_data_i[XLEN-1];
  assign w_sb   = rs2_sign_i & rs2_data_i[XLEN-1];
  assign w_mag1 = w_sa ? -rs1_data_i : rs1_data_i;
  assign w_mag2 = w_sb ? -rs2_data_i : rs2_data_i;
  assign w_div0 = rs2_data_i == '0;
  assign w_ovf  = rs1_sign_i & rs2_sign_i & (rs1_data_i == {1'b1, {(XLEN-1){1'b0}}}) & (&rs2_data_i);
  // r_op holds the multiplicand or divisor; r_lo the multiplier or dividend/quotient.
  assign w_add  = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_op} : '0);
  assign w_sh   = {r_hi, r_lo[XLEN-1]};
  assign w_diff = w_sh - {1'b0, r_op};
  assign stall_o = (r_state != DONE) & (req_valid_i | busy_o);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_op     <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_mul    <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      data_1_o <= '0;
      data_2_o <= '0;
      valid_o  <= 1'b0;
      busy_o   <= 1'b0;
    end else begin
      valid_o <= 1'b0;
      if (flush_i) begin
        r_state <= IDLE;
        busy_o  <= 1'b0;
      end else begin
        case (r_state)
          IDLE: if (req_valid_i) begin
            r_mul   <= mul_en_i;
            r_neg_q <= w_sa ^ w_sb;
            r_neg_r <= w_sa;
            r_op    <= w_mag2;
            r_lo    <= w_mag1;
            r_hi    <= '0;
            r_cnt   <= CNT_W'(XLEN-1);
            busy_o  <= 1'b1;
            if (!mul_en_i && (w_div0 || w_ovf)) begin
              r_state  <= DONE;
              valid_o  <= 1'b1;
              data_1_o <= w_div0 ? '1 : rs1_data_i;
              data_2_o <= w_div0 ? rs1_data_i : '0;
            end else r_state <= CALC;
          end
          CALC: begin
            if (r_mul) {r_hi, r_lo} <= {w_add, r_lo[XLEN-1:1]};
            else begin
              r_hi <= w_diff[XLEN] ? w_sh[XLEN-1:0] : w_diff[XLEN-1:0];
              r_lo <= {r_lo[XLEN-2:0], ~w_diff[XLEN]};
            end
            if (r_cnt == '0) r_state <= FIX;
            else r_cnt <= r_cnt - CNT_W'(1);
          end
          FIX: begin
            r_state <= DONE;
            valid_o <= 1'b1;
            if (r_mul) {data_2_o, data_1_o} <= r_neg_q ? -{r_hi, r_lo} : {r_hi, r_lo};
            else begin
              data_1_o <= r_neg_q ? -r_lo : r_lo;
              data_2_o <= r_neg_r ? -r_hi : r_hi;
            end
          end
          DONE: begin
            r_state <= IDLE;
            busy_o  <= 1'b0;
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq: directed-vector bench for the multiply/divide sequencer.
module tb_muldiv_seq;
  logic        clk = 1'b0, rst = 1'b1;
  logic        req = 1'b0, mul_en = 1'b0, s1 = 1'b0, s2 = 1'b0, flush = 1'b0;
  logic [63:0] rs1 = '0, rs2 = '0;
  logic [63:0] d1, d2;
  logic        valid, busy, stall;
  int          total = 0, bad = 0;

  muldiv_seq dut (
    .clk(clk), .rst(rst), .req_valid_i(req), .mul_en_i(mul_en),
    .rs1_data_i(rs1), .rs2_data_i(rs2), .rs1_sign_i(s1), .rs2_sign_i(s2),
    .flush_i(flush), .data_1_o(d1), .data_2_o(d2), .valid_o(valid),
    .busy_o(busy), .stall_o(stall)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic m, input logic [63:0] a, input logic [63:0] b, input logic sa, input logic sb);
    req = 1'b1; mul_en = m; rs1 = a; rs2 = b; s1 = sa; s2 = sb;
  endtask

  // Issues one op, returns cycles from acceptance to valid_o and how many cycles stall_o was wrong.
  task automatic run_op(input logic m, input logic [63:0] a, input logic [63:0] b, input logic sa, input logic sb,
                        output int lat, output int stall_bad);
    @(negedge clk);
    drive(m, a, b, sa, sb);
    #1 stall_bad = (stall !== 1'b1) ? 1 : 0;
    lat = -1;
    for (int n = 1; n <= 200; n++) begin
      @(negedge clk);
      if (valid === 1'b1) begin
        lat = n;
        if (stall !== 1'b0) stall_bad++;
        break;
      end else if (stall !== 1'b1) stall_bad++;
    end
    req = 1'b0;
  endtask

  task automatic test_reset;
    #2;
    total++; if (d1 !== 64'd0) begin bad++; $display("FAIL rst_d1: got %h want 0", d1); end
    total++; if (d2 !== 64'd0) begin bad++; $display("FAIL rst_d2: got %h want 0", d2); end
    total++; if (valid !== 1'b0) begin bad++; $display("FAIL rst_valid: got %b want 0", valid); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b want 0", busy); end
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL rst_stall: got %b want 0", stall); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_mul;
    int lat, sb;
    run_op(1'b1, 64'd3, 64'hFFFF_FFFF_FFFF_FFFB, 1'b1, 1'b1, lat, sb);
    total++; if (lat !== 66) begin bad++; $display("FAIL mul_lat: got %0d want 66", lat); end
    total++; if (sb !== 0) begin bad++; $display("FAIL mul_stall: got %0d bad cycles want 0", sb); end
    total++; if (d1 !== 64'hFFFF_FFFF_FFFF_FFF1) begin bad++; $display("FAIL mul_lo: got %h want fffffffffffffff1", d1); end
    total++; if (d2 !== 64'hFFFF_FFFF_FFFF_FFFF) begin bad++; $display("FAIL mul_hi: got %h want ffffffffffffffff", d2); end
    @(negedge clk);
    total++; if (valid !== 1'b0) begin bad++; $display("FAIL mul_pulse: got %b want 0", valid); end
    run_op(1'b1, '1, '1, 1'b0, 1'b0, lat, sb);
    total++; if (lat !== 66) begin bad++; $display("FAIL mulhu_lat: got %0d want 66", lat); end
    total++; if (d1 !== 64'h1) begin bad++; $display("FAIL mulhu_lo: got %h want 1", d1); end
    total++; if (d2 !== 64'hFFFF_FFFF_FFFF_FFFE) begin bad++; $display("FAIL mulhu_hi: got %h want fffffffffffffffe", d2); end
  endtask

  task automatic test_div;
    int lat, sb;
    run_op(1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 1'b1, 1'b1, lat, sb);
    total++; if (lat !== 66) begin bad++; $display("FAIL div_lat: got %0d want 66", lat); end
    total++; if (sb !== 0) begin bad++; $display("FAIL div_stall: got %0d bad cycles want 0", sb); end
    total++; if (d1 !== 64'hFFFF_FFFF_FFFF_FFFD) begin bad++; $display("FAIL div_q: got %h want fffffffffffffffd", d1); end
    total++; if (d2 !== 64'hFFFF_FFFF_FFFF_FFFF) begin bad++; $display("FAIL div_r: got %h want ffffffffffffffff", d2); end
    run_op(1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 1'b0, 1'b0, lat, sb);
    total++; if (d1 !== 64'h7FFF_FFFF_FFFF_FFFC) begin bad++; $display("FAIL divu_q: got %h want 7ffffffffffffffc", d1); end
    total++; if (d2 !== 64'd1) begin bad++; $display("FAIL divu_r: got %h want 1", d2); end
  endtask

  task automatic test_special;
    int lat, sb;
    run_op(1'b0, 64'd42, 64'd0, 1'b0, 1'b0, lat, sb);
    total++; if (lat !== 1) begin bad++; $display("FAIL div0_lat: got %0d want 1", lat); end
    total++; if (sb !== 0) begin bad++; $display("FAIL div0_stall: got %0d bad cycles want 0", sb); end
    total++; if (d1 !== 64'hFFFF_FFFF_FFFF_FFFF) begin bad++; $display("FAIL div0_q: got %h want ffffffffffffffff", d1); end
    total++; if (d2 !== 64'd42) begin bad++; $display("FAIL div0_r: got %h want 42", d2); end
    run_op(1'b0, 64'h8000_0000_0000_0000, '1, 1'b1, 1'b1, lat, sb);
    total++; if (lat !== 1) begin bad++; $display("FAIL ovf_lat: got %0d want 1", lat); end
    total++; if (d1 !== 64'h8000_0000_0000_0000) begin bad++; $display("FAIL ovf_q: got %h want 8000000000000000", d1); end
    total++; if (d2 !== 64'd0) begin bad++; $display("FAIL ovf_r: got %h want 0", d2); end
  endtask

  task automatic test_flush;
    int lat, sb, vcnt;
    run_op(1'b0, 64'd42, 64'd0, 1'b0, 1'b0, lat, sb);
    @(negedge clk);
    drive(1'b0, 64'd1000, 64'd3, 1'b0, 1'b0);
    vcnt = 0;
    for (int n = 1; n <= 29; n++) begin @(negedge clk); if (valid === 1'b1) vcnt++; end
    @(negedge clk);
    if (valid === 1'b1) vcnt++;
    flush = 1'b1; req = 1'b0;
    @(negedge clk);
    flush = 1'b0;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL flush_busy: got %b want 0", busy); end
    if (valid === 1'b1) vcnt++;
    @(negedge clk);
    drive(1'b0, 64'd100, 64'd7, 1'b0, 1'b0);
    lat = -1;
    for (int n = 33; n <= 70; n++) begin @(negedge clk); if (valid === 1'b1) vcnt++; end
    total++; if (vcnt !== 0) begin bad++; $display("FAIL flush_valid: got %0d pulses want 0", vcnt); end
    total++; if (d1 !== 64'hFFFF_FFFF_FFFF_FFFF) begin bad++; $display("FAIL flush_d1: got %h want ffffffffffffffff", d1); end
    total++; if (d2 !== 64'd42) begin bad++; $display("FAIL flush_d2: got %h want 42", d2); end
    for (int n = 71; n <= 120; n++) begin
      @(negedge clk);
      if (valid === 1'b1) begin lat = n; break; end
    end
    req = 1'b0;
    total++; if (lat !== 98) begin bad++; $display("FAIL flush_relat: got %0d want 98", lat); end
    total++; if (d1 !== 64'd14) begin bad++; $display("FAIL flush_q: got %h want 14", d1); end
    total++; if (d2 !== 64'd2) begin bad++; $display("FAIL flush_r: got %h want 2", d2); end
  endtask

  task automatic test_async_reset;
    int lat, sb;
    @(negedge clk);
    drive(1'b1, 64'd123, 64'd456, 1'b0, 1'b0);
    repeat (20) @(negedge clk);
    @(posedge clk);
    #3 rst = 1'b1; req = 1'b0;
    #1;
    total++; if (d1 !== 64'd0) begin bad++; $display("FAIL arst_d1: got %h want 0", d1); end
    total++; if (d2 !== 64'd0) begin bad++; $display("FAIL arst_d2: got %h want 0", d2); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL arst_busy: got %b want 0", busy); end
    total++; if (valid !== 1'b0) begin bad++; $display("FAIL arst_valid: got %b want 0", valid); end
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL arst_stall: got %b want 0", stall); end
    @(negedge clk);
    rst = 1'b0;
    run_op(1'b1, 64'd6, 64'd7, 1'b1, 1'b1, lat, sb);
    total++; if (lat !== 66) begin bad++; $display("FAIL arst_lat: got %0d want 66", lat); end
    total++; if (d1 !== 64'd42) begin bad++; $display("FAIL arst_lo: got %h want 42", d1); end
    total++; if (d2 !== 64'd0) begin bad++; $display("FAIL arst_hi: got %h want 0", d2); end
  endtask

  task automatic test_back_to_back;
    int lat1, lat2;
    @(negedge clk);
    drive(1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 64'd5, 1'b1, 1'b0);
    lat1 = -1; lat2 = -1;
    for (int n = 1; n <= 200; n++) begin
      @(negedge clk);
      if (valid === 1'b1) begin lat1 = n; break; end
    end
    total++; if (lat1 !== 66) begin bad++; $display("FAIL b2b_lat1: got %0d want 66", lat1); end
    total++; if (d1 !== 64'hFFFF_FFFF_FFFF_FFF6) begin bad++; $display("FAIL b2b_lo: got %h want fffffffffffffff6", d1); end
    total++; if (d2 !== 64'hFFFF_FFFF_FFFF_FFFF) begin bad++; $display("FAIL b2b_hi: got %h want ffffffffffffffff", d2); end
    rs1 = 64'd9; rs2 = 64'd11;
    @(negedge clk);
    total++; if (valid !== 1'b0) begin bad++; $display("FAIL b2b_pulse: got %b want 0", valid); end
    for (int m = 2; m <= 200; m++) begin
      @(negedge clk);
      if (valid === 1'b1) begin lat2 = m; break; end
    end
    req = 1'b0;
    total++; if (lat2 !== 67) begin bad++; $display("FAIL b2b_period: got %0d want 67", lat2); end
    total++; if (d1 !== 64'd99) begin bad++; $display("FAIL b2b_lo2: got %h want 99", d1); end
    @(negedge clk);
  endtask

  initial begin
    test_reset;
    test_mul;
    test_div;
    test_special;
    test_flush;
    test_async_reset;
    test_back_to_back;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/muldiv_seq.md
# muldiv_seq

Multi-cycle sequencer for the RV64 M-extension multiply/divide resource used by the execute stage. It accepts one request from EX: operands, per-operand sign flags, a multiply/divide select and a request strobe. It computes iteratively with one radix-2 step per cycle and returns two 64-bit result words on the EX `muldiv_data_1_i` / `muldiv_data_2_i` inputs. It also drives a pipeline stall while a request is in flight.

## Interface
Parameters:
- `XLEN`, default 64: operand and result width.
- `CNT_W`, default 6: iteration counter width; XLEN = 2^CNT_W.

Ports:
- `clk`, in, 1: single clock; all state updates on the rising edge.
- `rst`, in, 1: reset, asynchronous and active-high.
- `req_valid_i`, in, 1: EX request. Held high by EX until the result cycle.
- `mul_en_i`, in, 1: 1 selects multiply, 0 selects divide/remainder.
- `rs1_data_i`, in, XLEN: multiplicand or dividend.
- `rs2_data_i`, in, XLEN: multiplier or divisor.
- `rs1_sign_i`, in, 1: 1 means rs1 is treated as two's-complement signed.
- `rs2_sign_i`, in, 1: 1 means rs2 is treated as signed.
- `flush_i`, in, 1: kill the in-flight operation (branch redirect).
- `data_1_o`, out, XLEN: product low half, or quotient.
- `data_2_o`, out, XLEN: product high half, or remainder.
- `valid_o`, out, 1: one-cycle pulse; data_1_o and data_2_o are final in that cycle.
- `busy_o`, out, 1: state is not IDLE.
- `stall_o`, out, 1: combinational; freezes IF/ID/EX.

## Operation
- States: IDLE, CALC, FIX, DONE. All outputs except stall_o are registered.
- **IDLE**
  - When req_valid_i=1 and flush_i=0: latch operands, sign flags and mul_en_i.
  - Form magnitudes: |x| when the operand's sign flag is 1 and x[XLEN-1]=1, otherwise x unchanged. The magnitude of -2^63 is 2^63 as unsigned.
  - Record the result signs:
    - multiply: neg = sa ^ sb, where sa = rs1_sign_i & rs1[63] and sb = rs2_sign_i & rs2[63];
    - divide: quotient negative = sa ^ sb; remainder negative = sa.
  - Load counter with XLEN-1 and go to CALC.
- **Divide special cases** bypass CALC and go IDLE→DONE directly:
  - divisor == 0: data_1 = all ones, data_2 = rs1.
  - signed overflow (rs1_sign_i & rs2_sign_i, rs1 = 0x8000_0000_0000_0000, rs2 = all ones): data_1 = rs1, data_2 = 0.
- **CALC**, one step per cycle, exactly XLEN cycles; counter decrements and leaves at 0.
  - Multiply: 128-bit shift-add accumulator on the magnitudes.
  - Divide: restoring division. Shift the remainder left by one, bring in the next dividend bit, subtract the divisor if the result is non-negative, and shift the quotient bit in.
- **FIX** (1 cycle): conditionally two's-complement negate.
  - Multiply: negate the full 128-bit product.
  - Divide: negate quotient and remainder independently.
  - Then write data_1_o and data_2_o.
- **DONE** (1 cycle): valid_o=1, then go to IDLE unconditionally.
- data_1_o and data_2_o hold their value until the next result is written.
- stall_o = ~(state==DONE) & (req_valid_i | busy_o).
  - When stall_o falls, EX must advance.
  - A request still high in IDLE after DONE is treated as a new request and is recomputed.
- flush_i:
  - In any state, go to IDLE on the next edge. No valid_o pulse; data outputs are unchanged.
  - flush_i has priority over acceptance in IDLE.
  - In DONE, valid_o still pulses that cycle, since it is registered.
- rst (asynchronous): state=IDLE, counter=0, all accumulators=0, data_1_o=0, data_2_o=0, valid_o=0, busy_o=0.
  - Reset mid-operation discards the operation and no result is produced.

## Timing
- Accept edge k (IDLE, req_valid_i=1).
- Normal path: CALC in cycles k+1 to k+64, FIX in k+65, DONE/valid_o in k+66. Latency is 66 cycles from acceptance.
- Special divide path: DONE/valid_o in k+1.
- Back-to-back: the next acceptance is possible at the edge following DONE, giving a throughput of 1 op per 67 cycles.
- stall_o is 1 from the cycle req_valid_i rises through FIX, and 0 in DONE.
- busy_o is 1 in CALC, FIX and DONE.
- valid_o is never high for more than one consecutive cycle.

## Test plan
- **MUL signed 3 × -5**: accept at k → valid_o at k+66, data_1 = 0xFFFF_FFFF_FFFF_FFF1, data_2 = all ones. stall_o is 1 from k to k+65 and 0 at k+66.
- **MULHU** all ones × all ones (signs 0,0) → data_1 = 0x0000_0000_0000_0001, data_2 = 0xFFFF_FFFF_FFFF_FFFE.
- **DIV signed -7 / 2** → data_1 = 0xFFFF_FFFF_FFFF_FFFD (-3), data_2 = all ones (-1). DIVU with the same bits → quotient 0x7FFF_FFFF_FFFF_FFFC, remainder 1.
- **Special cases**, both must show valid_o at k+1:
  - DIVU 42 / 0 → data_1 = all ones, data_2 = 42.
  - DIV 0x8000_0000_0000_0000 / -1 → data_1 = 0x8000_0000_0000_0000, data_2 = 0.
- **flush_i pulse at k+30** during a divide → IDLE at k+31, no valid_o through k+70, data outputs unchanged. A new request at k+32 gives valid_o at k+98.
- **rst asserted asynchronously mid-CALC**, between clock edges → outputs read 0 immediately, busy_o = 0. After release, a fresh MUL 6 × 7 gives 42 / 0 with 66-cycle latency.
